// File: rtl/j11_bus_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : j11_bus_arb_if
// Description : Master-side and slave-side bus bundle of the J11 bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface j11_bus_arb_if #(
    parameter int N = 2
);
    logic [N-1:0]    m_req;
    logic [N-1:0]    m_wr;
    logic [N-1:0]    m_gp;
    logic [N-1:0]    m_irq;
    logic [22*N-1:0] m_addr;
    logic [16*N-1:0] m_wdata;
    logic [N-1:0]    m_ack;
    logic [N-1:0]    m_err;
    logic [15:0]     m_rdata;

    logic            s_req;
    logic            s_wr;
    logic            s_gp;
    logic            s_irq;
    logic [21:0]     s_addr;
    logic [15:0]     s_wdata;
    logic            s_ack;
    logic [15:0]     s_rdata;

    logic            busy;
    logic [N-1:0]    grant;

    // Arbiter view: it masters the shared slave bus.
    modport master (
        input  m_req, m_wr, m_gp, m_irq, m_addr, m_wdata, s_ack, s_rdata,
        output m_ack, m_err, m_rdata, s_req, s_wr, s_gp, s_irq, s_addr,
               s_wdata, busy, grant
    );

    // Environment view: requesters and the memory/IO slave.
    modport slave (
        output m_req, m_wr, m_gp, m_irq, m_addr, m_wdata, s_ack, s_rdata,
        input  m_ack, m_err, m_rdata, s_req, s_wr, s_gp, s_irq, s_addr,
               s_wdata, busy, grant
    );
endinterface
`default_nettype wire

// File: rtl/j11_bus_arb.sv
`default_nettype none
// ============================================================================
// Module      : j11_bus_arb
// Description : Round-robin arbiter of N single-transaction bus masters onto
//               one memory/IO slave. Optional slave timeout via macro
//               J11_BUS_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module j11_bus_arb #(
    parameter int N       = 2,
    parameter int TIMEOUT = 255,
    parameter int RR_INIT = N - 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    j11_bus_arb_if.master bus
);
    localparam int              PW        = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0]   c_rr_init = PW'(RR_INIT);
    localparam logic [N-1:0]    c_one     = N'(1);

    generate
        if (N < 2 || N > 8) begin : g_bad_n
            $error("j11_bus_arb: N must be 2..8");
        end
        if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
            $error("j11_bus_arb: TIMEOUT must be 1..65535");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [N-1:0]    r_pending;
    logic [N-1:0]    r_grant;
    logic [N-1:0]    r_m_ack;
    logic [15:0]     r_m_rdata;
    logic [PW-1:0]   r_last;
    logic [PW-1:0]   r_gidx;
    logic            r_s_wr;
    logic            r_s_gp;
    logic            r_s_irq;
    logic [21:0]     r_s_addr;
    logic [15:0]     r_s_wdata;

    logic [PW-1:0]   w_pick;
    logic            w_found;
    logic            w_start;
    logic            w_done_ok;
    logic            w_done_err;
    logic            w_done;
    logic            w_tmo;
    logic [N-1:0]    w_clr;

    // First pending master strictly after the last winner, wrapping at N.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= N; k++) begin
            if (!w_found && r_pending[(int'(r_last) + k) % N]) begin
                w_found = 1'b1;
                w_pick  = PW'((int'(r_last) + k) % N);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done_ok   = 1'b0;
        w_done_err  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_start     = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.s_ack) begin
                    w_done_ok   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_tmo) begin
                    w_done_err  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_done = w_done_ok | w_done_err;
    assign w_clr  = w_done ? r_grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_last    <= c_rr_init;
            r_m_ack   <= '0;
            r_m_rdata <= '0;
            r_s_wr    <= 1'b0;
            r_s_gp    <= 1'b0;
            r_s_irq   <= 1'b0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
        end else begin
            // Pending drops in the same edge that raises m_ack; a new request wins.
            r_pending <= (r_pending & ~w_clr) | bus.m_req;
            r_m_ack   <= '0;
            if (w_start) begin
                r_grant   <= c_one << w_pick;
                r_gidx    <= w_pick;
                r_s_wr    <= bus.m_wr[w_pick];
                r_s_gp    <= bus.m_gp[w_pick];
                r_s_irq   <= bus.m_irq[w_pick];
                r_s_addr  <= bus.m_addr[22*w_pick +: 22];
                r_s_wdata <= bus.m_wdata[16*w_pick +: 16];
            end
            if (w_done) begin
                r_m_ack   <= r_grant;
                r_m_rdata <= w_done_ok ? bus.s_rdata : 16'h0000;
                r_last    <= r_gidx;
                r_grant   <= '0;
            end
        end
    end

`ifdef J11_BUS_ARB_TIMEOUT_EN
    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT - 1);

    logic [15:0]  r_cnt;
    logic [N-1:0] r_m_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_cnt <= '0;
        end else if (r_state == WAIT && !bus.s_ack) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // s_ack has priority: timeout only fires on a cycle without it.
    assign w_tmo = (r_state == WAIT) && !bus.s_ack && (r_cnt == c_tmo_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_err <= '0;
        end else begin
            r_m_err <= w_done_err ? r_grant : '0;
        end
    end

    assign bus.m_err = r_m_err;
`else
    assign w_tmo     = 1'b0;
    assign bus.m_err = '0;
`endif

    assign bus.m_ack   = r_m_ack;
    assign bus.m_rdata = r_m_rdata;
    assign bus.s_req   = (r_state == ISSUE);
    assign bus.s_wr    = r_s_wr;
    assign bus.s_gp    = r_s_gp;
    assign bus.s_irq   = r_s_irq;
    assign bus.s_addr  = r_s_addr;
    assign bus.s_wdata = r_s_wdata;
    assign bus.busy    = (r_state != IDLE);
    assign bus.grant   = r_grant;

endmodule
`default_nettype wire
